// File: rtl/epl_write_sequencer_if.sv
// Handshake/bus bundle between the write requester and epl_write_sequencer.
`ifndef TWORD_WIDTH
`define TWORD_WIDTH 8
`endif
`ifndef ADDR_AYO
`define ADDR_AYO 2
`endif

interface epl_write_sequencer_if;
  logic                    pReq_i;
  logic                    pColSel_i;
  logic [`TWORD_WIDTH-1:0] pWdata_i;
  logic                    pReady_o;
  logic [`ADDR_AYO-1:0]    pAcy_o;
  logic                    pValide_o;
  logic [`TWORD_WIDTH-1:0] pCodeword_o;
  logic                    pBusy_o;
  logic                    pDone_o;

  // Sequencer side
  modport slave (
    input  pReq_i, pColSel_i, pWdata_i,
    output pReady_o, pAcy_o, pValide_o, pCodeword_o, pBusy_o, pDone_o
  );

  // Requester side
  modport master (
    output pReq_i, pColSel_i, pWdata_i,
    input  pReady_o, pAcy_o, pValide_o, pCodeword_o, pBusy_o, pDone_o
  );
endinterface

// File: rtl/epl_write_sequencer.sv
// Write sequencer: holds pValide_o for WR_CYCLES, then REC_CYCLES of recovery,
// with a one-entry pending buffer so back-to-back writes have no idle bubble.
`ifndef TWORD_WIDTH
`define TWORD_WIDTH 8
`endif
`ifndef ADDR_AYO
`define ADDR_AYO 2
`endif

module epl_write_sequencer #(
  parameter int unsigned WR_CYCLES  = 4,
  parameter int unsigned REC_CYCLES = 1
) (
  input  logic                 pClk_i,
  input  logic                 nRst_i,
  epl_write_sequencer_if.slave bus
);
  localparam int TW = `TWORD_WIDTH;
  localparam logic [3:0] WR_LOAD  = 4'(WR_CYCLES);
  localparam logic [3:0] REC_LOAD = 4'(REC_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WRITE   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  act_sel_q, act_sel_d;
  logic [TW-1:0]         act_data_q, act_data_d;
  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_sel_q, pend_sel_d;
  logic [TW-1:0]         pend_data_q, pend_data_d;
  logic [`ADDR_AYO-1:0]  acy_q, acy_d;
  logic                  valide_q, valide_d;
  logic [TW-1:0]         cw_q, cw_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept_s;

  // Column parity bit to one-hot column select.
  function automatic logic [`ADDR_AYO-1:0] col_onehot(input logic sel);
    return sel ? `ADDR_AYO'(2'b10) : `ADDR_AYO'(2'b01);
  endfunction

  // Ready depends only on the pending register, so acceptance never loops back through pReq_i.
  assign accept_s = bus.pReq_i & ~pend_vld_q;

  // Next-state, counter, active and pending register updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_sel_d   = act_sel_q;
    act_data_d  = act_data_q;
    pend_vld_d  = pend_vld_q;
    pend_sel_d  = pend_sel_q;
    pend_data_d = pend_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d    = S_WRITE;
          cnt_d      = WR_LOAD;
          act_sel_d  = bus.pColSel_i;
          act_data_d = bus.pWdata_i;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      S_WRITE: begin
        if (accept_s) begin
          pend_vld_d  = 1'b1;
          pend_sel_d  = bus.pColSel_i;
          pend_data_d = bus.pWdata_i;
        end else begin
          pend_vld_d = pend_vld_q;
        end
        if (cnt_q <= 4'd1) begin
          state_d = S_RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q <= 4'd1) begin
          // Last recovery cycle: the pending entry wins over a fresh request.
          if (pend_vld_q) begin
            state_d    = S_WRITE;
            cnt_d      = WR_LOAD;
            act_sel_d  = pend_sel_q;
            act_data_d = pend_data_q;
            pend_vld_d = 1'b0;
          end else if (accept_s) begin
            state_d    = S_WRITE;
            cnt_d      = WR_LOAD;
            act_sel_d  = bus.pColSel_i;
            act_data_d = bus.pWdata_i;
          end else begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (accept_s) begin
            pend_vld_d  = 1'b1;
            pend_sel_d  = bus.pColSel_i;
            pend_data_d = bus.pWdata_i;
          end else begin
            pend_vld_d = pend_vld_q;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        cnt_d      = 4'd0;
        pend_vld_d = 1'b0;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so outputs are registers.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    valide_d = (state_d == S_WRITE);
    done_d   = (state_d == S_RECOVER) && (cnt_d == 4'd1);
    acy_d    = busy_d ? col_onehot(act_sel_d) : `ADDR_AYO'(2'b00);
    cw_d     = busy_d ? act_data_d : '0;
  end

  // State, datapath and output registers; reset aborts any in-flight or pending write.
  always_ff @(posedge pClk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      act_sel_q   <= 1'b0;
      act_data_q  <= '0;
      pend_vld_q  <= 1'b0;
      pend_sel_q  <= 1'b0;
      pend_data_q <= '0;
      acy_q       <= `ADDR_AYO'(2'b00);
      valide_q    <= 1'b0;
      cw_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_sel_q   <= act_sel_d;
      act_data_q  <= act_data_d;
      pend_vld_q  <= pend_vld_d;
      pend_sel_q  <= pend_sel_d;
      pend_data_q <= pend_data_d;
      acy_q       <= acy_d;
      valide_q    <= valide_d;
      cw_q        <= cw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.pReady_o    = ~pend_vld_q;
  assign bus.pAcy_o      = acy_q;
  assign bus.pValide_o   = valide_q;
  assign bus.pCodeword_o = cw_q;
  assign bus.pBusy_o     = busy_q;
  assign bus.pDone_o     = done_q;

endmodule

// File: tb/tb_epl_write_sequencer.sv
// Bench for epl_write_sequencer: directed vector tables, hand-written corner
// sequences, and random traffic against a schedule-based reference model.
module tb_epl_write_sequencer;
  localparam int WR  = 4;
  localparam int REC = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  epl_write_sequencer_if bus_a ();
  epl_write_sequencer_if bus_b ();

  epl_write_sequencer #(.WR_CYCLES(WR), .REC_CYCLES(REC)) dut_a (
    .pClk_i(clk), .nRst_i(rst_n), .bus(bus_a)
  );
  epl_write_sequencer #(.WR_CYCLES(1), .REC_CYCLES(1)) dut_b (
    .pClk_i(clk), .nRst_i(rst_n), .bus(bus_b)
  );

  int n_vec = 0;
  int n_mis = 0;

  typedef struct {
    logic        req;
    logic        sel;
    logic [7:0]  data;
    logic [13:0] exp;
  } row_t;
  row_t tbl[$];

  typedef struct {
    logic       sel;
    logic [7:0] data;
  } wr_t;

  // Reference model: a write started at cycle s is valid on s..s+WR-1,
  // recovers on s+WR..s+WR+REC-1 and pulses done on its last cycle.
  int  m_cyc;
  bit  m_act;
  int  m_s;
  wr_t m_cur;
  wr_t m_pend[$];

  function automatic logic [13:0] pack(input logic rdy, input logic val, input logic [1:0] acy,
                                       input logic [7:0] cw, input logic done, input logic busy);
    return {rdy, val, acy, cw, done, busy};
  endfunction

  function automatic logic [13:0] obs_a();
    return pack(bus_a.pReady_o, bus_a.pValide_o, bus_a.pAcy_o, bus_a.pCodeword_o,
                bus_a.pDone_o, bus_a.pBusy_o);
  endfunction

  function automatic logic [13:0] obs_b();
    return pack(bus_b.pReady_o, bus_b.pValide_o, bus_b.pAcy_o, bus_b.pCodeword_o,
                bus_b.pDone_o, bus_b.pBusy_o);
  endfunction

  function automatic void add(input int n, input logic req, input logic sel, input logic [7:0] data,
                              input logic rdy, input logic val, input logic [1:0] acy,
                              input logic [7:0] cw, input logic done, input logic busy);
    row_t r;
    r.req  = req;
    r.sel  = sel;
    r.data = data;
    r.exp  = pack(rdy, val, acy, cw, done, busy);
    for (int i = 0; i < n; i++) tbl.push_back(r);
  endfunction

  function automatic void add_single_write(input logic sel, input logic [7:0] data);
    logic [1:0] a;
    a = sel ? 2'b10 : 2'b01;
    add(1,  1'b1, sel, data,   1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    add(WR, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, a,     data,  1'b0, 1'b1);
    add(1,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a,     data,  1'b1, 1'b1);
    add(1,  1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("%s[%0d]", tag, i), obs_a(), tbl[i].exp);
      bus_a.pReq_i     = tbl[i].req;
      bus_a.pColSel_i  = tbl[i].sel;
      bus_a.pWdata_i   = tbl[i].data;
    end
  endtask

  function automatic logic [13:0] m_expect();
    int off;
    logic rdy;
    rdy = (m_pend.size() == 0);
    if (!m_act) return pack(rdy, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    off = m_cyc - m_s;
    return pack(rdy, off < WR, m_cur.sel ? 2'b10 : 2'b01, m_cur.data, off == WR + REC - 1, 1'b1);
  endfunction

  function automatic void m_edge(input logic req, input logic sel, input logic [7:0] data);
    bit  accept;
    wr_t w;
    w.sel  = sel;
    w.data = data;
    accept = req && (m_pend.size() == 0);
    if (!m_act) begin
      if (accept) begin m_act = 1'b1; m_s = m_cyc + 1; m_cur = w; end
    end else if (m_cyc - m_s == WR + REC - 1) begin
      if (m_pend.size() > 0) begin
        m_s = m_cyc + 1; m_cur = m_pend.pop_front();
      end else if (accept) begin
        m_s = m_cyc + 1; m_cur = w;
      end else begin
        m_act = 1'b0;
      end
    end else if (accept) begin
      m_pend.push_back(w);
    end
    m_cyc++;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] log_q[$];
    int   sent;
    bit   saw_block;
    logic prev_val;
    logic [13:0] rst_exp;

    rst_exp = pack(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    bus_a.pReq_i = 1'b0; bus_a.pColSel_i = 1'b0; bus_a.pWdata_i = 8'h00;
    bus_b.pReq_i = 1'b0; bus_b.pColSel_i = 1'b0; bus_b.pWdata_i = 8'h00;

    // Reset values while nRst_i is low
    repeat (3) @(negedge clk);
    chk("reset_a", obs_a(), rst_exp);
    chk("reset_b", obs_b(), rst_exp);
    rst_n = 1'b1;

    // Directed table: single write, back-to-back, last-cycle acceptance
    tbl.delete();
    add_single_write(1'b1, 8'hA5);
    add(1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    add(1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 2'b10, 8'h5A, 1'b0, 1'b1);
    add(WR - 1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10, 8'h5A, 1'b0, 1'b1);
    add(1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 8'h5A, 1'b1, 1'b1);
    add(WR, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 8'h3C, 1'b0, 1'b1);
    add(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'h3C, 1'b1, 1'b1);
    add(1, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    add(WR, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b01, 8'h77, 1'b0, 1'b1);
    add(1, 1'b1, 1'b1, 8'h88, 1'b1, 1'b0, 2'b01, 8'h77, 1'b1, 1'b1);
    add(WR, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 8'h88, 1'b0, 1'b1);
    add(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 8'h88, 1'b1, 1'b1);
    add(1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    run_table("dir");

    // Full buffer: requests held until accepted; each value written once, in order
    sent = 0; saw_block = 1'b0; prev_val = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus_a.pValide_o && !prev_val) log_q.push_back(bus_a.pCodeword_o);
      prev_val = bus_a.pValide_o;
      if (sent < 3) begin
        if (bus_a.pReq_i && !bus_a.pReady_o) saw_block = 1'b1;
        bus_a.pReq_i    = 1'b1;
        bus_a.pColSel_i = sent[0];
        bus_a.pWdata_i  = 8'(8'h11 * (sent + 1));
        if (bus_a.pReady_o) sent++;
      end else begin
        bus_a.pReq_i = 1'b0;
      end
    end
    chk("fb_blocked", 14'(saw_block), 14'd1);
    chk("fb_count", 14'(log_q.size()), 14'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("fb_data%0d", i), (i < log_q.size()) ? 14'(log_q[i]) : 14'h3fff,
          14'(8'(8'h11 * (i + 1))));

    // Reset mid-WRITE (cycle 2, pending full)
    @(negedge clk);
    bus_a.pReq_i = 1'b1; bus_a.pColSel_i = 1'b1; bus_a.pWdata_i = 8'hA5;
    @(negedge clk);
    bus_a.pReq_i = 1'b1; bus_a.pColSel_i = 1'b0; bus_a.pWdata_i = 8'h3C;
    @(negedge clk);
    bus_a.pReq_i = 1'b0;
    chk("rst_pre", obs_a(), pack(1'b0, 1'b1, 2'b10, 8'hA5, 1'b0, 1'b1));
    #1 rst_n = 1'b0;
    #1 chk("rst_async", obs_a(), rst_exp);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d", k), obs_a(), rst_exp);
    end
    rst_n = 1'b1;
    tbl.delete();
    add_single_write(1'b1, 8'hA5);
    run_table("post_rst");

    // Random traffic against the reference model
    m_cyc = 0; m_act = 1'b0; m_s = 0; m_pend.delete();
    for (int k = 0; k < 400; k++) begin
      logic       r;
      logic       s;
      logic [7:0] d;
      @(negedge clk);
      chk($sformatf("rand[%0d]", k), obs_a(), m_expect());
      r = ($urandom_range(0, 9) < 5);
      s = 1'($urandom);
      d = 8'($urandom);
      bus_a.pReq_i = r; bus_a.pColSel_i = s; bus_a.pWdata_i = d;
      m_edge(r, s, d);
    end
    @(negedge clk);
    bus_a.pReq_i = 1'b0;

    // WR_CYCLES=1, REC_CYCLES=1 with continuous requests
    bus_b.pReq_i = 1'b1; bus_b.pColSel_i = 1'b0; bus_b.pWdata_i = 8'h42;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("alt[%0d]", k), {12'd0, bus_b.pValide_o, bus_b.pDone_o},
          {12'd0, (k % 2 == 1), (k % 2 == 0)});
    end
    bus_b.pReq_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule

// File: doc/epl_write_sequencer.md
EPL_WRITE_SEQUENCER -- requirements
Module: epl_write_sequencer

Interface
REQ-001 Parameter WR_CYCLES, default 4, number of consecutive cycles pValide_o is held per write (legal 1..15).
REQ-002 Parameter REC_CYCLES, default 1, number of recovery cycles after each write pulse (legal 1..15).
REQ-003 pClk_i  input  1  single clock, all state updates on rising edge.
REQ-004 nRst_i  input  1  asynchronous, active-low reset.
REQ-005 pReq_i  input  1  write request, qualified by pReady_o.
REQ-006 pColSel_i  input  1  column parity: 0 = even columns, 1 = odd columns.
REQ-007 pWdata_i  input  `TWORD_WIDTH  codeword to write.
REQ-008 pReady_o  output  1  request acceptance (one-entry pending buffer not full).
REQ-009 pAcy_o  output  `ADDR_AYO  one-hot column select to column-access stage.
REQ-010 pValide_o  output  1  write-valid to column-access stage.
REQ-011 pCodeword_o  output  `TWORD_WIDTH  codeword to column-access stage.
REQ-012 pBusy_o  output  1  high whenever state is not IDLE.
REQ-013 pDone_o  output  1  one-cycle pulse on the last RECOVER cycle of each write.

Function
REQ-014 Acceptance SHALL occur on a rising edge where pReq_i=1 and pReady_o=1; pReady_o SHALL equal NOT pending_valid (register-driven, no combinational path from pReq_i).
REQ-015 FSM SHALL have states IDLE, WRITE, RECOVER.
REQ-016 IDLE: on acceptance, pColSel_i/pWdata_i SHALL load the active registers and next state SHALL be WRITE; pending buffer stays empty.
REQ-017 WRITE: pValide_o=1 for exactly WR_CYCLES consecutive cycles, then RECOVER.
REQ-018 RECOVER: pValide_o=0 for exactly REC_CYCLES cycles; pDone_o=1 on the last of them.
REQ-019 At RECOVER exit: pending valid -> load active from pending, clear pending, go WRITE; else acceptance in that same cycle -> load active directly, go WRITE; else go IDLE.
REQ-020 Acceptance in WRITE, or in RECOVER other than its last cycle, SHALL store the request in the pending buffer.
REQ-021 pAcy_o SHALL be 2'b01 for pColSel=0 and 2'b10 for pColSel=1 throughout WRITE and RECOVER, and 2'b00 in IDLE.
REQ-022 pCodeword_o SHALL equal the active codeword in WRITE and RECOVER and all zeros in IDLE.
REQ-023 Active registers SHALL not change during WRITE or RECOVER except at the RECOVER-exit load.
REQ-024 Back-to-back writes SHALL have zero IDLE bubble: pValide_o low exactly REC_CYCLES cycles between them.
REQ-025 Downstream registers pWe one cycle after pValide_o; no extra latency compensation SHALL be added here.
REQ-026 Cycle counter SHALL be 4 bits, reloaded on each state entry, never wrapping.

Reset
REQ-027 While nRst_i=0: state=IDLE, counter=0, pending cleared, pReady_o=1, pAcy_o=2'b00, pValide_o=0, pCodeword_o=0, pBusy_o=0, pDone_o=0.
REQ-028 Reset asserted mid-WRITE or mid-RECOVER SHALL abort immediately; the in-flight and pending writes are discarded and pDone_o is not issued.
REQ-029 After reset release, the first rising edge with pReq_i=1 SHALL be accepted.

Verification
REQ-030 Single write, defaults: pReq_i pulse, pColSel_i=1, pWdata_i=0xA5 in IDLE -> next cycle pAcy_o=2'b10, pCodeword_o=0xA5, pValide_o high 4 cycles, 1 RECOVER cycle with pDone_o=1, then IDLE with pAcy_o=2'b00.
REQ-031 Back-to-back: second request (pColSel_i=0, data 0x3C) during WRITE -> pReady_o low next cycle, second write starts right after RECOVER, pAcy_o=2'b01, pValide_o gap exactly 1 cycle.
REQ-032 Full buffer: third request held while pending full -> not accepted (pReady_o=0) until pending drains, then accepted; every data value written exactly once, in order.
REQ-033 Last-cycle acceptance: request arrives only on the final RECOVER cycle with pending empty -> WRITE follows with no IDLE cycle and pReady_o stays 1.
REQ-034 WR_CYCLES=1, REC_CYCLES=1: continuous pReq_i -> pValide_o alternates 1,0 each cycle and pDone_o pulses every second cycle.
REQ-035 Reset mid-WRITE (cycle 2 of 4, pending full) -> all outputs at reset values in the same cycle, no pDone_o, and the next request after release behaves as in REQ-030.
